// File: rtl/vospi_packet_filter.sv
// VoSPI packet filter: frames the raw byte stream into packets, drops discard and
// out-of-sequence packets, and forwards payload bytes tagged with line/frame markers.
module vospi_packet_filter #(
   parameter int  packet_bytes_p  = 164,
   parameter int  frame_packets_p = 60,
   localparam int line_width_lp   = $clog2(frame_packets_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     flush_i,
   input  logic [7:0]               data_i,
   input  logic                     valid_i,
   output logic [7:0]               data_o,
   output logic                     valid_o,
   output logic                     sof_o,
   output logic                     eol_o,
   output logic                     eof_o,
   output logic [line_width_lp-1:0] line_o,
   output logic                     in_sync_o,
   output logic [7:0]               err_count_o
);
   localparam int cnt_width_lp = $clog2(packet_bytes_p);
   localparam logic [cnt_width_lp-1:0]  last_byte_lp     = cnt_width_lp'(packet_bytes_p - 1);
   localparam logic [cnt_width_lp-1:0]  first_payload_lp = cnt_width_lp'(4);
   localparam logic [cnt_width_lp-1:0]  id_lo_byte_lp    = cnt_width_lp'(1);
   localparam logic [11:0]              last_pkt_lp      = 12'(frame_packets_p - 1);
   localparam logic [line_width_lp-1:0] last_line_lp     = line_width_lp'(frame_packets_p - 1);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

   state_e                   state_q, state_d;
   logic [cnt_width_lp-1:0]  byte_cnt_q, byte_cnt_d;
   logic [3:0]               id_hi_q, id_hi_d;
   logic                     accept_q, accept_d;
   logic [11:0]              expected_q, expected_d;
   logic [line_width_lp-1:0] pkt_q, pkt_d;
   logic [7:0]               err_q, err_d;
   logic [7:0]               data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     sof_q, sof_d;
   logic                     eol_q, eol_d;
   logic                     eof_q, eof_d;
   logic [line_width_lp-1:0] line_q, line_d;

   logic [11:0] pkt_num;
   logic        hdr_ev, discard, pkt_zero, pkt_match, fwd, in_sync;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Header decode happens while the second ID byte is on the input.
   always_comb begin
      pkt_num   = {id_hi_q, data_i};
      hdr_ev    = valid_i && (byte_cnt_q == id_lo_byte_lp);
      discard   = (id_hi_q == 4'hF);
      pkt_zero  = (pkt_num == 12'd0);
      pkt_match = (state_q == LOCKED) && (pkt_num == expected_q);
      fwd       = valid_i && accept_q && (byte_cnt_q >= first_payload_lp);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= HUNT;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i)
         state_d = HUNT;
      else if (hdr_ev && !discard)
         state_d = (pkt_zero || pkt_match) ? LOCKED : HUNT;
   end

   always_comb begin
      in_sync = (state_q == LOCKED);
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      id_hi_d    = id_hi_q;
      accept_d   = accept_q;
      expected_d = expected_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      data_d     = data_q;
      line_d     = line_q;
      valid_d    = 1'b0;
      sof_d      = 1'b0;
      eol_d      = 1'b0;
      eof_d      = 1'b0;

      if (valid_i)
         byte_cnt_d = (byte_cnt_q == last_byte_lp) ? '0 : byte_cnt_q + 1'b1;
      if (valid_i && (byte_cnt_q == '0))
         id_hi_d = data_i[3:0];

      if (hdr_ev) begin
         accept_d = 1'b0;
         if (!discard) begin
            pkt_d = pkt_num[line_width_lp-1:0];
            if (pkt_zero) begin
               accept_d   = 1'b1;
               expected_d = 12'd1;
               if (in_sync && (expected_q != 12'd0)) err_d = sat_inc(err_q);
            end else if (pkt_match) begin
               accept_d   = 1'b1;
               expected_d = (pkt_num == last_pkt_lp) ? 12'd0 : expected_q + 12'd1;
            end else if (in_sync) begin
               err_d = sat_inc(err_q);
            end
         end
      end

      if (fwd) begin
         valid_d = 1'b1;
         data_d  = data_i;
         line_d  = pkt_q;
         sof_d   = (byte_cnt_q == first_payload_lp) && (pkt_q == '0);
         eol_d   = (byte_cnt_q == last_byte_lp);
         eof_d   = (byte_cnt_q == last_byte_lp) && (pkt_q == last_line_lp);
      end

      // Flush behaves like reset but keeps the error history.
      if (flush_i) begin
         byte_cnt_d = '0;
         id_hi_d    = '0;
         accept_d   = 1'b0;
         expected_d = '0;
         pkt_d      = '0;
         err_d      = err_q;
         data_d     = '0;
         line_d     = '0;
         valid_d    = 1'b0;
         sof_d      = 1'b0;
         eol_d      = 1'b0;
         eof_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         byte_cnt_q <= '0;
         id_hi_q    <= '0;
         accept_q   <= 1'b0;
         expected_q <= '0;
         pkt_q      <= '0;
         err_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eol_q      <= 1'b0;
         eof_q      <= 1'b0;
         line_q     <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         id_hi_q    <= id_hi_d;
         accept_q   <= accept_d;
         expected_q <= expected_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eol_q      <= eol_d;
         eof_q      <= eof_d;
         line_q     <= line_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign sof_o       = sof_q;
   assign eol_o       = eol_q;
   assign eof_o       = eof_q;
   assign line_o      = line_q;
   assign in_sync_o   = in_sync;
   assign err_count_o = err_q;

endmodule

// File: tb/tb_vospi_packet_filter.sv
// Bench for vospi_packet_filter: packet-level reference model plus scenario tasks.
module tb_vospi_packet_filter;
   localparam int PB = 164;
   localparam int FP = 60;
   localparam int PL = PB - 4;

   logic       clk = 1'b0, reset_n = 1'b0, flush = 1'b0, valid = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout, errc;
   logic       vout, sof, eol, eof, insync;
   logic [5:0] lno;

   vospi_packet_filter #(.packet_bytes_p(PB), .frame_packets_p(FP)) dut (
      .clk_i(clk), .reset_ni(reset_n), .flush_i(flush), .data_i(din), .valid_i(valid),
      .data_o(dout), .valid_o(vout), .sof_o(sof), .eol_o(eol), .eof_o(eof),
      .line_o(lno), .in_sync_o(insync), .err_count_o(errc));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eol;
      logic       eof;
      logic [5:0] line;
   } beat_t;

   beat_t obs_q[$];
   beat_t exp_q[$];
   int    tests = 0, fails = 0, stray = 0;
   bit    m_sync = 0;
   int    m_exp = 0, m_err = 0;
   logic  sync_b0, sync_b1;

   // One input cycle; outputs for this byte are visible right after the edge.
   task automatic drive(input logic [7:0] d, input logic v, input logic f);
      beat_t b;
      din = d; valid = v; flush = f;
      @(posedge clk); #1;
      if (vout) begin
         b = {dout, sof, eol, eof, lno};
         obs_q.push_back(b);
      end
      if (!vout && (sof || eol || eof)) stray++;
      valid = 1'b0; flush = 1'b0;
   endtask

   // Whole-packet reference: decides the packet from its ID, then lists the bytes it must emit.
   task automatic model_packet(input int id, input logic [7:0] pl [PL], input int nbytes);
      int    pn;
      bit    acc;
      beat_t b;
      pn  = id & 'hFFF;
      acc = 0;
      if (nbytes < 2) return;
      if ((pn >> 8) != 15) begin
         if (pn == 0) begin
            if (m_sync && m_exp != 0 && m_err < 255) m_err++;
            acc = 1; m_sync = 1; m_exp = 1;
         end else if (m_sync && pn == m_exp) begin
            acc = 1; m_exp = (pn == FP - 1) ? 0 : pn + 1;
         end else begin
            if (m_sync && m_err < 255) m_err++;
            m_sync = 0;
         end
      end
      if (acc)
         for (int i = 0; i < PL && i + 4 < nbytes; i++) begin
            b.d = pl[i]; b.sof = (pn == 0 && i == 0); b.eol = (i == PL - 1);
            b.eof = (i == PL - 1 && pn == FP - 1); b.line = 6'(pn);
            exp_q.push_back(b);
         end
   endtask

   task automatic model_reset(input bit keep_err);
      m_sync = 0; m_exp = 0;
      if (!keep_err) m_err = 0;
   endtask

   task automatic send_packet(input int id, input int nbytes, input int gap_pct, input bit rnd_pl);
      logic [7:0] pl [PL];
      logic [7:0] b;
      for (int i = 0; i < PL; i++)
         pl[i] = rnd_pl ? 8'($urandom) : 8'(((id & 'hFFF) * PL + i) % 256);
      model_packet(id, pl, nbytes);
      for (int k = 0; k < nbytes; k++) begin
         while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) drive(8'($urandom), 1'b0, 1'b0);
         if (k == 0)      b = 8'(id >> 8);
         else if (k == 1) b = 8'(id);
         else if (k < 4)  b = 8'($urandom);
         else             b = pl[k - 4];
         drive(b, 1'b1, 1'b0);
         if (k == 0) sync_b0 = insync;
         if (k == 1) sync_b1 = insync;
      end
   endtask

   task automatic hw_reset();
      reset_n = 1'b0;
      drive(8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      model_reset(0);
   endtask

   task automatic clear_q();
      obs_q.delete(); exp_q.delete(); stray = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) drive(8'($urandom), 1'b1, 1'b0);
      tests++; if (vout !== 1'b0) begin fails++; $display("FAIL reset valid_o: got %b want 0", vout); end
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset data_o: got %h want 00", dout); end
      tests++; if ({sof, eol, eof} !== 3'b000) begin fails++; $display("FAIL reset markers: got %b want 000", {sof, eol, eof}); end
      tests++; if (lno !== 6'd0) begin fails++; $display("FAIL reset line_o: got %0d want 0", lno); end
      tests++; if (insync !== 1'b0) begin fails++; $display("FAIL reset in_sync_o: got %b want 0", insync); end
      tests++; if (errc !== 8'd0) begin fails++; $display("FAIL reset err_count_o: got %0d want 0", errc); end
      reset_n = 1'b1;
      model_reset(0);
      drive(8'h00, 1'b0, 1'b0);
   endtask

   // Starts mid-frame, then a full clean frame (payload = frame byte index mod 256).
   task automatic test_mid_frame_clean();
      int n_sof, n_eol, n_eof, bad_pat, nbad, first;
      clear_q();
      for (int p = 30; p < FP; p++) send_packet(p, PB, 0, 0);
      tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mid_frame drop: got %0d beats want 0", obs_q.size()); end
      tests++; if (errc !== 8'd0) begin fails++; $display("FAIL mid_frame err: got %0d want 0", errc); end
      for (int p = 0; p < FP; p++) send_packet(p, PB, 0, 0);
      n_sof = 0; n_eol = 0; n_eof = 0; bad_pat = 0;
      foreach (obs_q[i]) begin
         n_sof += int'(obs_q[i].sof); n_eol += int'(obs_q[i].eol); n_eof += int'(obs_q[i].eof);
         if (obs_q[i].d !== 8'(i % 256) || obs_q[i].line !== 6'(i / PL)) bad_pat++;
      end
      tests++; if (obs_q.size() != 9600) begin fails++; $display("FAIL clean valid count: got %0d want 9600", obs_q.size()); end
      tests++; if (!(n_sof == 1 && obs_q.size() > 0 && obs_q[0].sof)) begin fails++; $display("FAIL clean sof: got %0d pulses want 1 on byte 0", n_sof); end
      tests++; if (n_eol != 60) begin fails++; $display("FAIL clean eol count: got %0d want 60", n_eol); end
      tests++; if (!(n_eof == 1 && obs_q.size() == 9600 && obs_q[9599].eof)) begin fails++; $display("FAIL clean eof: got %0d pulses want 1 on byte 9599", n_eof); end
      tests++; if (bad_pat != 0) begin fails++; $display("FAIL clean data/line pattern: got %0d bad beats want 0", bad_pat); end
      tests++; if (errc !== 8'd0) begin fails++; $display("FAIL clean err: got %0d want 0", errc); end
      tests++; if (stray != 0) begin fails++; $display("FAIL clean stray markers: got %0d want 0", stray); end
      nbad = 0; first = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
      tests++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL clean stream: got %0d beats %0d differ (first %0d) want %0d beats", obs_q.size(), nbad, first, exp_q.size()); end
   endtask

   task automatic test_discard_interleave();
      int bad_pat, n_eol, nbad, first;
      clear_q();
      for (int p = 0; p <= 10; p++) send_packet(p, PB, 0, 0);
      for (int j = 0; j < 3; j++) begin
         send_packet(int'(16'hFF00) | $urandom_range(255, 0), PB, 0, 1);
         tests++; if (insync !== 1'b1) begin fails++; $display("FAIL discard in_sync after discard %0d: got %b want 1", j, insync); end
      end
      for (int p = 11; p < FP; p++) send_packet(p, PB, 0, 0);
      bad_pat = 0; n_eol = 0;
      foreach (obs_q[i]) begin
         n_eol += int'(obs_q[i].eol);
         if (obs_q[i].d !== 8'(i % 256) || obs_q[i].line !== 6'(i / PL)) bad_pat++;
      end
      tests++; if (obs_q.size() != 9600) begin fails++; $display("FAIL discard valid count: got %0d want 9600", obs_q.size()); end
      tests++; if (bad_pat != 0 || n_eol != 60) begin fails++; $display("FAIL discard pattern: got %0d bad, %0d eol want 0 bad, 60 eol", bad_pat, n_eol); end
      tests++; if (errc !== 8'd0) begin fails++; $display("FAIL discard err: got %0d want 0", errc); end
      nbad = 0; first = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
      tests++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL discard stream: got %0d beats %0d differ (first %0d) want %0d beats", obs_q.size(), nbad, first, exp_q.size()); end
   endtask

   task automatic test_lost_packet();
      int nbad, first;
      clear_q();
      for (int p = 0; p <= 20; p++) send_packet(p, PB, 0, 0);
      send_packet(22, PB, 0, 0);
      tests++; if (sync_b0 !== 1'b1 || sync_b1 !== 1'b0) begin fails++; $display("FAIL lost in_sync edge: got %b%b want 10", sync_b0, sync_b1); end
      tests++; if (errc !== 8'd1) begin fails++; $display("FAIL lost err: got %0d want 1", errc); end
      for (int p = 23; p <= 25; p++) send_packet(p, PB, 0, 0);
      send_packet(0, PB, 0, 0);
      tests++; if (obs_q.size() != 22 * PL) begin fails++; $display("FAIL lost beat count: got %0d want %0d", obs_q.size(), 22 * PL); end
      tests++; if (!(obs_q.size() > 21 * PL && obs_q[21 * PL].sof && obs_q[21 * PL].line == 6'd0)) begin fails++; $display("FAIL lost relock sof: got beats %0d want sof at %0d", obs_q.size(), 21 * PL); end
      tests++; if (insync !== 1'b1 || errc !== 8'd1) begin fails++; $display("FAIL lost relock state: got sync %b err %0d want 1/1", insync, errc); end
      nbad = 0; first = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
      tests++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL lost stream: got %0d beats %0d differ (first %0d) want %0d beats", obs_q.size(), nbad, first, exp_q.size()); end
   endtask

   task automatic test_reset_mid_payload();
      int nbad, first;
      clear_q();
      for (int p = 0; p <= 4; p++) send_packet(p, PB, 0, 0);
      send_packet(5, 80, 0, 0);
      #3 reset_n = 1'b0;
      #1;
      tests++; if ({vout, sof, eol, eof} !== 4'b0000 || dout !== 8'h00 || lno !== 6'd0) begin fails++; $display("FAIL rst_mid outputs: got v%b m%b%b%b d%h l%0d want all 0", vout, sof, eol, eof, dout, lno); end
      tests++; if (insync !== 1'b0 || errc !== 8'd0) begin fails++; $display("FAIL rst_mid state: got sync %b err %0d want 0/0", insync, errc); end
      reset_n = 1'b1;
      model_reset(0);
      send_packet(6, PB, 0, 0);
      send_packet(0, PB, 0, 0);
      tests++; if (obs_q.size() != 5 * PL + 76 + PL) begin fails++; $display("FAIL rst_mid beat count: got %0d want %0d", obs_q.size(), 5 * PL + 76 + PL); end
      tests++; if (insync !== 1'b1) begin fails++; $display("FAIL rst_mid relock: got %b want 1", insync); end
      nbad = 0; first = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
      tests++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_mid stream: got %0d beats %0d differ (first %0d) want %0d beats", obs_q.size(), nbad, first, exp_q.size()); end
   endtask

   task automatic test_flush_mid_payload();
      int nbad, first;
      clear_q();
      for (int p = 0; p <= 4; p++) send_packet(p, PB, 0, 0);
      send_packet(5, 80, 0, 0);
      drive(8'($urandom), 1'b1, 1'b1);
      tests++; if ({vout, sof, eol, eof} !== 4'b0000 || dout !== 8'h00 || lno !== 6'd0) begin fails++; $display("FAIL flush outputs: got v%b m%b%b%b d%h l%0d want all 0", vout, sof, eol, eof, dout, lno); end
      tests++; if (insync !== 1'b0) begin fails++; $display("FAIL flush in_sync: got %b want 0", insync); end
      tests++; if (errc !== 8'd1 || errc !== 8'(m_err)) begin fails++; $display("FAIL flush err kept: got %0d want 1 (model %0d)", errc, m_err); end
      model_reset(1);
      send_packet(6, PB, 0, 0);
      send_packet(0, PB, 0, 0);
      tests++; if (obs_q.size() != 5 * PL + 76 + PL || insync !== 1'b1) begin fails++; $display("FAIL flush rehunt: got %0d beats sync %b want %0d beats sync 1", obs_q.size(), insync, 5 * PL + 76 + PL); end
      nbad = 0; first = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
      tests++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL flush stream: got %0d beats %0d differ (first %0d) want %0d beats", obs_q.size(), nbad, first, exp_q.size()); end
   endtask

   task automatic test_saturation();
      hw_reset();
      clear_q();
      send_packet(0, PB, 0, 1);
      for (int e = 1; e <= 300; e++) begin
         send_packet(0, PB, 0, 1);
         if (e == 254) begin
            tests++; if (errc !== 8'd254) begin fails++; $display("FAIL sat pre-limit: got %0d want 254", errc); end
         end
      end
      tests++; if (errc !== 8'd255) begin fails++; $display("FAIL sat hold: got %0d want 255", errc); end
      tests++; if (errc !== 8'(m_err) || insync !== 1'b1) begin fails++; $display("FAIL sat model: got err %0d sync %b want %0d/1", errc, insync, m_err); end
      tests++; if (obs_q.size() != 301 * PL) begin fails++; $display("FAIL sat beats: got %0d want %0d", obs_q.size(), 301 * PL); end
   endtask

   task automatic test_random();
      int id, r, nbad, first;
      hw_reset();
      clear_q();
      for (int n = 0; n < 16; n++) begin
         r = $urandom_range(99, 0);
         if (r < 45)      id = m_sync ? m_exp : $urandom_range(FP - 1, 0);
         else if (r < 60) id = 0;
         else if (r < 75) id = ('hF << 8) | $urandom_range(255, 0);
         else             id = $urandom_range(4095, 0);
         id = id | ($urandom_range(15, 0) << 12);
         send_packet(id, PB, 10, 1);
         tests++; if (errc !== 8'(m_err) || insync !== m_sync) begin fails++; $display("FAIL random pkt %0d id %h: got err %0d sync %b want %0d/%0d", n, id, errc, insync, m_err, m_sync); end
      end
      tests++; if (stray != 0) begin fails++; $display("FAIL random stray markers: got %0d want 0", stray); end
      nbad = 0; first = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
      tests++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL random stream: got %0d beats %0d differ (first %0d) want %0d beats", obs_q.size(), nbad, first, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_mid_frame_clean();
      test_discard_interleave();
      test_lost_packet();
      test_reset_mid_payload();
      test_flush_mid_payload();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
